pea_core_gen2: RTL and testbench
================================

PEA_CORE_GEN2 -- requirements
Module: pea_core_gen2

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of command and data tokens; result and status tokens are 2*WORD_SIZE bits wide.
REQ-002 Parameter BUFFER_SIZE, default 1024: FIFO depth; population and free-space ports are log2(BUFFER_SIZE) bits wide.
REQ-003 Parameter NUM_VEC, default 8, range 1..8: number of coefficient vectors stored.
REQ-004 Parameter MAX_DEG, default 10, range 1..31: highest polynomial degree accepted.
REQ-005 Port list, one per line:
- clk  in  1  the single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- command_in  in  WORD_SIZE  head of the command FIFO (first-word-fall-through).
- command_pop  in  log2(BUFFER_SIZE)  command FIFO population.
- data_in  in  WORD_SIZE  head of the data FIFO, signed.
- data_pop  in  log2(BUFFER_SIZE)  data FIFO population.
- result_free_space  in  log2(BUFFER_SIZE)  free words in the result FIFO.
- status_free_space  in  log2(BUFFER_SIZE)  free words in the status FIFO.
- invoke  in  1  firing request.
- enable  out  1  firing precondition met (combinational).
- command_rd_en, data_rd_en  out  1  pop strobes.
- result_wr_en, status_wr_en  out  1  push strobes.
- result_out, status_out  out  2*WORD_SIZE  output tokens.
- FC  out  1  firing-complete pulse.

Function
REQ-006 Command token fields: [15:8] opcode (STP=8'h01, EVP=8'h02, EVB=8'h03, RST=8'h04), [7:5] a (vector index), [4:0] b (argument).
REQ-007 Per vector a, the block stores S[a][0..MAX_DEG] (WORD_SIZE-bit signed) and N[a]; N[a] is invalid until STP succeeds on vector a.
REQ-008 enable = (command_pop>=1) and (status_free_space>=1) and the opcode requirement of the decoded head command:
- STP: data_pop>=b+1.
- EVP: data_pop>=1 and result_free_space>=1.
- EVB: data_pop>=b and result_free_space>=b.
- RST, and any command that fails the REQ-010 checks: no further requirement.
REQ-009 The FSM has states IDLE, DECODE, STP_LOAD, EV_FETCH, EV_HORNER, EV_WRITE, STATUS and DONE; invoke is honoured only in IDLE with enable=1, and is ignored otherwise.
REQ-010 DECODE:
- Pulses command_rd_en for one cycle and latches the token.
- Error checks, first match wins: unknown opcode -> code 1; a>=NUM_VEC -> code 2; STP with b>MAX_DEG -> code 3; EVP/EVB with N[a] invalid -> code 4; EVB with b=0 -> code 5.
- On error, goes to STATUS with no data read and no result written.
REQ-011 STP: data_rd_en is high for b+1 consecutive cycles, storing S[a][i]=data_in for i=0..b in arrival order; then N[a]=b and code 0.
REQ-012 RST: sets N[a] invalid, reads no data, and reports code 0.
REQ-013 EVP/EVB, for each of k x-tokens (k=1 for EVP, k=b for EVB):
- EV_FETCH pulses data_rd_en once and latches x.
- EV_HORNER runs N[a]+1 cycles: acc starts at S[a][N[a]], then acc = acc*x + S[a][i] for i descending to 0.
- EV_WRITE pulses result_wr_en with result_out=acc.
REQ-014 Arithmetic: acc is 2*WORD_SIZE-bit signed; each product and sum is truncated to its low 2*WORD_SIZE bits (two's-complement wrap) with no saturation and no overflow flag.
REQ-015 STATUS pulses status_wr_en exactly once per firing, with status_out = {code in low 8 bits, zero-extended}.
REQ-016 DONE asserts FC for one cycle, then the FSM returns to IDLE; an invoke in the DONE cycle is ignored.
REQ-017 At most one of command_rd_en/data_rd_en and at most one of result_wr_en/status_wr_en is high in any cycle; strobes are never asserted outside the states listed above.
REQ-018 A successful STP to a vector whose N is already valid overwrites it; coefficients above the new degree are don't-care.
REQ-019 EVP latency from invoke to FC is N[a]+7 cycles, deterministic and independent of data values.

Reset
REQ-020 While rst=1 at a clock edge:
- State goes to IDLE.
- All N[] become invalid.
- All strobe outputs, FC, result_out and status_out are 0.
- S contents are don't-care.
REQ-021 A reset mid-firing abandons the firing immediately: no further pops or pushes, and no FC for that firing.

Verification
REQ-022 The bench shall cover these directed scenarios:
- STP a=0 b=2, data 1,2,3 -> 3 data pops, status 0, FC once; then EVP a=0 x=2 -> result 17, status 0.
- EVB a=0 b=3, x=-1,0,1 -> results 2,1,6 in order, then one status 0; total data pops = 3.
- EVP a=5 after reset -> status 4, zero data pops, zero result writes.
- Opcode 8'h7F -> status 1.
- STP b=12 with MAX_DEG=10 -> status 3 and data_pop unchanged.
- EVB b=4 with result_free_space=3 -> enable=0 and invoke ignored; raising free space to 4 -> the firing proceeds.
- rst asserted during EV_HORNER -> no FC, outputs 0; a subsequent EVP a=0 -> status 4.

Source files
------------

// File: rtl/pea_core_gen2.sv
// Polynomial evaluation actor: stores coefficient vectors from the data FIFO and
// evaluates them with Horner's rule, one token per firing, with a status token each firing.
module pea_core_gen2 #(
    parameter int WORD_SIZE   = 16,
    parameter int BUFFER_SIZE = 1024,
    parameter int NUM_VEC     = 8,
    parameter int MAX_DEG     = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WORD_SIZE-1:0]           command_in,
    input  logic [$clog2(BUFFER_SIZE)-1:0] command_pop,
    input  logic [WORD_SIZE-1:0]           data_in,
    input  logic [$clog2(BUFFER_SIZE)-1:0] data_pop,
    input  logic [$clog2(BUFFER_SIZE)-1:0] result_free_space,
    input  logic [$clog2(BUFFER_SIZE)-1:0] status_free_space,
    input  logic                           invoke,
    output logic                           enable,
    output logic                           command_rd_en,
    output logic                           data_rd_en,
    output logic                           result_wr_en,
    output logic                           status_wr_en,
    output logic [2*WORD_SIZE-1:0]         result_out,
    output logic [2*WORD_SIZE-1:0]         status_out,
    output logic                           FC
);

    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int RW = 2 * WORD_SIZE;
    localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int DW = $clog2(MAX_DEG + 1);

    localparam logic [7:0] OP_STP = 8'h01;
    localparam logic [7:0] OP_EVP = 8'h02;
    localparam logic [7:0] OP_EVB = 8'h03;
    localparam logic [7:0] OP_RST = 8'h04;

    localparam logic [7:0] ST_OK       = 8'd0;
    localparam logic [7:0] ST_BAD_OP   = 8'd1;
    localparam logic [7:0] ST_BAD_VEC  = 8'd2;
    localparam logic [7:0] ST_BAD_DEG  = 8'd3;
    localparam logic [7:0] ST_NO_VEC   = 8'd4;
    localparam logic [7:0] ST_ZERO_CNT = 8'd5;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        STP_LOAD,
        EV_FETCH,
        EV_HORNER,
        EV_WRITE,
        STATUS,
        DONE
    } state_t;

    state_t state, state_next;

    logic [NUM_VEC-1:0]          n_valid;
    logic [4:0]                  n_deg [NUM_VEC];
    logic signed [WORD_SIZE-1:0] coef [NUM_VEC][MAX_DEG+1];

    logic [2:0]                  cmd_a;
    logic [4:0]                  cmd_b;
    logic [4:0]                  deg;
    logic [4:0]                  load_cnt;
    logic [4:0]                  h_cnt;
    logic [4:0]                  ev_left;
    logic [7:0]                  code;
    logic signed [WORD_SIZE-1:0] x_reg;
    logic signed [RW-1:0]        acc;

    logic [7:0]                  head_op;
    logic [2:0]                  head_a;
    logic [4:0]                  head_b;
    logic [PW-1:0]               head_b_w;
    logic [7:0]                  head_code;
    logic                        op_ready;

    logic [4:0]                  coef_idx;
    logic signed [WORD_SIZE-1:0] coef_rd;
    logic signed [RW-1:0]        coef_ext;
    logic signed [RW-1:0]        x_ext;

    assign head_op  = command_in[15:8];
    assign head_a   = command_in[7:5];
    assign head_b   = command_in[4:0];
    assign head_b_w = PW'(head_b);

    // The head command is judged before it is popped, so enable can see its error code.
    always_comb begin
        head_code = ST_OK;
        if (!(head_op inside {OP_STP, OP_EVP, OP_EVB, OP_RST})) begin
            head_code = ST_BAD_OP;
        end else if (int'(head_a) >= NUM_VEC) begin
            head_code = ST_BAD_VEC;
        end else if (head_op == OP_STP && int'(head_b) > MAX_DEG) begin
            head_code = ST_BAD_DEG;
        end else if ((head_op == OP_EVP || head_op == OP_EVB) && !n_valid[head_a[VW-1:0]]) begin
            head_code = ST_NO_VEC;
        end else if (head_op == OP_EVB && head_b == 5'd0) begin
            head_code = ST_ZERO_CNT;
        end
    end

    always_comb begin
        op_ready = 1'b1;
        if (head_code == ST_OK) begin
            case (head_op)
                OP_STP:  op_ready = data_pop >= head_b_w + PW'(1);
                OP_EVP:  op_ready = (data_pop != '0) && (result_free_space != '0);
                OP_EVB:  op_ready = (data_pop >= head_b_w) && (result_free_space >= head_b_w);
                default: op_ready = 1'b1;
            endcase
        end
    end

    assign enable = (command_pop != '0) && (status_free_space != '0) && op_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (invoke && enable) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (head_code != ST_OK) begin
                    state_next = STATUS;
                end else begin
                    case (head_op)
                        OP_STP:         state_next = STP_LOAD;
                        OP_EVP, OP_EVB: state_next = EV_FETCH;
                        default:        state_next = STATUS;
                    endcase
                end
            end
            STP_LOAD: begin
                if (load_cnt == cmd_b) begin
                    state_next = STATUS;
                end
            end
            EV_FETCH:  state_next = EV_HORNER;
            EV_HORNER: begin
                if (h_cnt == deg) begin
                    state_next = EV_WRITE;
                end
            end
            EV_WRITE: begin
                state_next = (ev_left == 5'd1) ? STATUS : EV_FETCH;
            end
            STATUS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Horner walks the coefficients from S[deg] down to S[0] as h_cnt counts up.
    assign coef_idx = deg - h_cnt;
    assign coef_rd  = coef[cmd_a[VW-1:0]][DW'(coef_idx)];
    assign coef_ext = RW'(coef_rd);
    assign x_ext    = RW'(x_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            n_valid  <= '0;
            cmd_a    <= '0;
            cmd_b    <= '0;
            deg      <= '0;
            load_cnt <= '0;
            h_cnt    <= '0;
            ev_left  <= '0;
            code     <= '0;
            x_reg    <= '0;
            acc      <= '0;
        end else begin
            case (state)
                DECODE: begin
                    cmd_a    <= head_a;
                    cmd_b    <= head_b;
                    code     <= head_code;
                    deg      <= n_deg[head_a[VW-1:0]];
                    load_cnt <= '0;
                    ev_left  <= (head_op == OP_EVB) ? head_b : 5'd1;
                    if (head_code == ST_OK && head_op == OP_RST) begin
                        n_valid[head_a[VW-1:0]] <= 1'b0;
                    end
                end
                STP_LOAD: begin
                    load_cnt <= load_cnt + 5'd1;
                    if (load_cnt == cmd_b) begin
                        n_valid[cmd_a[VW-1:0]] <= 1'b1;
                        n_deg[cmd_a[VW-1:0]]   <= cmd_b;
                    end
                end
                EV_FETCH: begin
                    x_reg <= data_in;
                    h_cnt <= '0;
                end
                EV_HORNER: begin
                    h_cnt <= h_cnt + 5'd1;
                    if (h_cnt == 5'd0) begin
                        acc <= coef_ext;
                    end else begin
                        acc <= acc * x_ext + coef_ext;
                    end
                end
                EV_WRITE: ev_left <= ev_left - 5'd1;
                default: ;
            endcase
        end
    end

    // Coefficient storage has no reset; its contents only matter once N[a] is valid.
    always_ff @(posedge clk) begin
        if (!rst && state == STP_LOAD) begin
            coef[cmd_a[VW-1:0]][DW'(load_cnt)] <= data_in;
        end
    end

    always_comb begin
        command_rd_en = 1'b0;
        data_rd_en    = 1'b0;
        result_wr_en  = 1'b0;
        status_wr_en  = 1'b0;
        FC            = 1'b0;
        result_out    = '0;
        status_out    = '0;
        case (state)
            DECODE:             command_rd_en = 1'b1;
            STP_LOAD, EV_FETCH: data_rd_en    = 1'b1;
            EV_WRITE: begin
                result_wr_en = 1'b1;
                result_out   = acc;
            end
            STATUS: begin
                status_wr_en = 1'b1;
                status_out   = {{(RW-8){1'b0}}, code};
            end
            DONE:    FC = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pea_core_gen2.sv
// Scoreboard bench for pea_core_gen2: FIFOs and a coefficient model live in the bench,
// expected result/status tokens are queued when commands are issued.
module tb_pea_core_gen2;

    localparam int WORD_SIZE   = 16;
    localparam int BUFFER_SIZE = 1024;
    localparam int NUM_VEC     = 8;
    localparam int MAX_DEG     = 10;
    localparam int PW          = $clog2(BUFFER_SIZE);

    localparam logic [7:0] OP_STP = 8'h01;
    localparam logic [7:0] OP_EVP = 8'h02;
    localparam logic [7:0] OP_EVB = 8'h03;
    localparam logic [7:0] OP_RST = 8'h04;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [WORD_SIZE-1:0]   command_in;
    logic [PW-1:0]          command_pop;
    logic [WORD_SIZE-1:0]   data_in;
    logic [PW-1:0]          data_pop;
    logic [PW-1:0]          result_free_space;
    logic [PW-1:0]          status_free_space;
    logic                   invoke;
    logic                   enable;
    logic                   command_rd_en;
    logic                   data_rd_en;
    logic                   result_wr_en;
    logic                   status_wr_en;
    logic [2*WORD_SIZE-1:0] result_out;
    logic [2*WORD_SIZE-1:0] status_out;
    logic                   FC;

    always #5 clk = ~clk;

    pea_core_gen2 #(
        .WORD_SIZE(WORD_SIZE),
        .BUFFER_SIZE(BUFFER_SIZE),
        .NUM_VEC(NUM_VEC),
        .MAX_DEG(MAX_DEG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .command_in(command_in),
        .command_pop(command_pop),
        .data_in(data_in),
        .data_pop(data_pop),
        .result_free_space(result_free_space),
        .status_free_space(status_free_space),
        .invoke(invoke),
        .enable(enable),
        .command_rd_en(command_rd_en),
        .data_rd_en(data_rd_en),
        .result_wr_en(result_wr_en),
        .status_wr_en(status_wr_en),
        .result_out(result_out),
        .status_out(status_out),
        .FC(FC)
    );

    logic [15:0] cmd_q[$];
    logic [15:0] data_q[$];
    logic [15:0] stim_x[$];
    logic [31:0] exp_res_q[$];
    logic [31:0] exp_stat_q[$];

    logic signed [15:0] mdl_s [8][32];
    logic [4:0]         mdl_deg [8];
    logic [7:0]         mdl_valid;

    int tests = 0;
    int failures = 0;
    int cmd_pops = 0;
    int data_pops = 0;
    int res_writes = 0;
    int stat_writes = 0;
    int fc_count = 0;
    int last_latency = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic refreshInputs();
        command_in  = (cmd_q.size() > 0) ? cmd_q[0] : '0;
        command_pop = PW'(cmd_q.size());
        data_in     = (data_q.size() > 0) ? data_q[0] : '0;
        data_pop    = PW'(data_q.size());
    endtask

    // One clock: observe the DUT mid-cycle, then retire popped FIFO words after the edge.
    task automatic tick();
        logic pop_c, pop_d;
        @(negedge clk);
        pop_c = command_rd_en;
        pop_d = data_rd_en;
        checkOutput("rd_exclusive", {31'b0, command_rd_en & data_rd_en}, 32'd0);
        checkOutput("wr_exclusive", {31'b0, result_wr_en & status_wr_en}, 32'd0);
        if (pop_c) cmd_pops++;
        if (pop_d) data_pops++;
        if (result_wr_en) begin
            res_writes++;
            checkOutput("result_expected", 32'(exp_res_q.size() > 0), 32'd1);
            if (exp_res_q.size() > 0) checkOutput("result_value", result_out, exp_res_q.pop_front());
        end
        if (status_wr_en) begin
            stat_writes++;
            checkOutput("status_expected", 32'(exp_stat_q.size() > 0), 32'd1);
            if (exp_stat_q.size() > 0) checkOutput("status_value", status_out, exp_stat_q.pop_front());
        end
        if (FC) fc_count++;
        @(posedge clk);
        #1;
        if (pop_c && cmd_q.size() > 0) void'(cmd_q.pop_front());
        if (pop_d && data_q.size() > 0) void'(data_q.pop_front());
        refreshInputs();
    endtask

    function automatic logic [31:0] polyEval(input logic [2:0] v, input logic [15:0] x);
        logic signed [31:0] acc, xe, ce;
        xe  = 32'(signed'(x));
        acc = 32'(mdl_s[v][mdl_deg[v]]);
        for (int i = int'(mdl_deg[v]) - 1; i >= 0; i--) begin
            ce  = 32'(mdl_s[v][5'(i)]);
            acc = acc * xe + ce;
        end
        return acc;
    endfunction

    function automatic logic [7:0] expectedCode(input logic [7:0] op, input logic [2:0] a, input logic [4:0] b);
        if (!(op inside {OP_STP, OP_EVP, OP_EVB, OP_RST})) return 8'd1;
        if (int'(a) >= NUM_VEC) return 8'd2;
        if (op == OP_STP && int'(b) > MAX_DEG) return 8'd3;
        if ((op == OP_EVP || op == OP_EVB) && !mdl_valid[a]) return 8'd4;
        if (op == OP_EVB && b == 5'd0) return 8'd5;
        return 8'd0;
    endfunction

    // Pushes the command plus stim_x data words and predicts the tokens the firing must emit.
    task automatic queueCommand(input logic [7:0] op, input logic [2:0] a, input logic [4:0] b);
        logic [7:0] code;
        code = expectedCode(op, a, b);
        cmd_q.push_back({op, a, b});
        foreach (stim_x[i]) data_q.push_back(stim_x[i]);
        if (code == 8'd0) begin
            case (op)
                OP_STP: begin
                    for (int i = 0; i <= int'(b); i++) mdl_s[a][5'(i)] = signed'(stim_x[i]);
                    mdl_valid[a] = 1'b1;
                    mdl_deg[a]   = b;
                end
                OP_RST: mdl_valid[a] = 1'b0;
                OP_EVP: exp_res_q.push_back(polyEval(a, stim_x[0]));
                OP_EVB: for (int i = 0; i < int'(b); i++) exp_res_q.push_back(polyEval(a, stim_x[i]));
                default: ;
            endcase
        end
        exp_stat_q.push_back(32'(code));
        stim_x.delete();
        refreshInputs();
    endtask

    // last_latency counts cycles with the invoke cycle as 1 and the FC cycle as the last.
    task automatic fireAndWait(input int budget);
        int start_fc;
        int cyc;
        start_fc = fc_count;
        invoke = 1'b1;
        tick();
        invoke = 1'b0;
        cyc = 1;
        while (fc_count == start_fc && cyc < budget) begin
            tick();
            cyc++;
        end
        checkOutput("fc_once", 32'(fc_count - start_fc), 32'd1);
        last_latency = cyc;
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] a, input logic [4:0] b);
        queueCommand(op, a, b);
        fireAndWait(200);
    endtask

    int d0, r0, s0, f0, c0;

    task automatic snapshot();
        d0 = data_pops; r0 = res_writes; s0 = stat_writes; f0 = fc_count; c0 = cmd_pops;
    endtask

    initial begin
        rst = 1'b1;
        invoke = 1'b0;
        result_free_space = PW'(500);
        status_free_space = PW'(500);
        mdl_valid = '0;
        refreshInputs();
        repeat (3) tick();
        rst = 1'b0;

        checkOutput("reset_fc", {31'b0, FC}, 32'd0);
        checkOutput("reset_strobes", {28'b0, command_rd_en, data_rd_en, result_wr_en, status_wr_en}, 32'd0);
        checkOutput("reset_result_out", result_out, 32'd0);
        checkOutput("reset_status_out", status_out, 32'd0);
        checkOutput("reset_enable_empty", {31'b0, enable}, 32'd0);

        snapshot();
        applyStimulus(OP_EVP, 3'd5, 5'd0);
        checkOutput("evp_invalid_data_pops", 32'(data_pops - d0), 32'd0);
        checkOutput("evp_invalid_results", 32'(res_writes - r0), 32'd0);
        checkOutput("evp_invalid_status", 32'(stat_writes - s0), 32'd1);

        applyStimulus(8'h7F, 3'd0, 5'd0);

        snapshot();
        stim_x = '{16'd1, 16'd2, 16'd3};
        applyStimulus(OP_STP, 3'd0, 5'd2);
        checkOutput("stp_data_pops", 32'(data_pops - d0), 32'd3);
        checkOutput("stp_status", 32'(stat_writes - s0), 32'd1);

        stim_x = '{16'd2};
        applyStimulus(OP_EVP, 3'd0, 5'd0);
        checkOutput("evp_latency_deg2", 32'(last_latency), 32'd9);

        snapshot();
        stim_x = '{16'hFFFF, 16'd0, 16'd1};
        applyStimulus(OP_EVB, 3'd0, 5'd3);
        checkOutput("evb_data_pops", 32'(data_pops - d0), 32'd3);
        checkOutput("evb_results", 32'(res_writes - r0), 32'd3);
        checkOutput("evb_status", 32'(stat_writes - s0), 32'd1);

        snapshot();
        stim_x = '{16'd9, 16'd9};
        applyStimulus(OP_STP, 3'd1, 5'd12);
        checkOutput("stp_bad_deg_data_pop", 32'(data_pop), 32'd2);
        checkOutput("stp_bad_deg_pops", 32'(data_pops - d0), 32'd0);
        data_q.delete();
        refreshInputs();

        snapshot();
        result_free_space = PW'(3);
        stim_x = '{16'hFFFE, 16'd3, 16'd0, 16'd5};
        queueCommand(OP_EVB, 3'd0, 5'd4);
        #1;
        checkOutput("evb_space_enable_low", {31'b0, enable}, 32'd0);
        invoke = 1'b1;
        repeat (4) tick();
        invoke = 1'b0;
        checkOutput("evb_space_cmd_held", 32'(cmd_q.size()), 32'd1);
        checkOutput("evb_space_no_status", 32'(stat_writes - s0), 32'd0);
        result_free_space = PW'(4);
        #1;
        checkOutput("evb_space_enable_high", {31'b0, enable}, 32'd1);
        fireAndWait(200);
        checkOutput("evb_space_results", 32'(res_writes - r0), 32'd4);
        result_free_space = PW'(500);

        stim_x = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        applyStimulus(OP_STP, 3'd1, 5'd3);
        stim_x = '{16'h7FFF};
        applyStimulus(OP_EVP, 3'd1, 5'd0);
        checkOutput("evp_latency_deg3", 32'(last_latency), 32'd10);
        stim_x = '{16'h8000};
        applyStimulus(OP_EVP, 3'd1, 5'd0);

        stim_x = '{16'd4, 16'hFFF9};
        applyStimulus(OP_STP, 3'd1, 5'd1);
        stim_x = '{16'd3};
        applyStimulus(OP_EVP, 3'd1, 5'd0);
        checkOutput("evp_latency_deg1", 32'(last_latency), 32'd8);

        snapshot();
        applyStimulus(OP_RST, 3'd1, 5'd0);
        checkOutput("rst_cmd_data_pops", 32'(data_pops - d0), 32'd0);
        applyStimulus(OP_EVP, 3'd1, 5'd0);
        applyStimulus(OP_EVB, 3'd0, 5'd0);

        // Abandon an EVP while it is inside the Horner loop.
        snapshot();
        cmd_q.push_back({OP_EVP, 3'd0, 5'd0});
        data_q.push_back(16'd3);
        refreshInputs();
        invoke = 1'b1;
        tick();
        invoke = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_valid = '0;
        checkOutput("midrst_fc", {31'b0, FC}, 32'd0);
        checkOutput("midrst_strobes", {28'b0, command_rd_en, data_rd_en, result_wr_en, status_wr_en}, 32'd0);
        checkOutput("midrst_result_out", result_out, 32'd0);
        checkOutput("midrst_status_out", status_out, 32'd0);
        repeat (10) tick();
        checkOutput("midrst_no_fc", 32'(fc_count - f0), 32'd0);
        checkOutput("midrst_no_result", 32'(res_writes - r0), 32'd0);
        checkOutput("midrst_no_status", 32'(stat_writes - s0), 32'd0);
        checkOutput("midrst_data_pops", 32'(data_pops - d0), 32'd1);
        checkOutput("midrst_cmd_pops", 32'(cmd_pops - c0), 32'd1);
        applyStimulus(OP_EVP, 3'd0, 5'd0);

        repeat (3) tick();
        checkOutput("results_drained", 32'(exp_res_q.size()), 32'd0);
        checkOutput("status_drained", 32'(exp_stat_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
